// File: rtl/tx_arb_mux.sv
// tx_arb_mux: arbitrates CH packet channels onto one PHY-facing beat stream.
// A sop beat wins the arbiter in IDLE, and its channel then owns the output
// until its eop beat is accepted. Beats pass through a 2-entry FIFO, so the
// latency is one cycle and a full bandwidth of 1 beat/cycle is possible.
// Optional feature: define TX_ARB_RR_EN for round-robin arbitration. The
// default build uses fixed priority, where the lowest channel index wins.
module tx_arb_mux #(
  parameter int CH  = 2,
  parameter int DW  = 8,
  parameter int CIW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH-1:0]     tx_in_sop,
  input  logic [CH-1:0]     tx_in_eop,
  input  logic [CH-1:0]     tx_in_valid,
  output logic [CH-1:0]     tx_in_ready,
  input  logic [CH*DW-1:0]  tx_in_data,
  output logic              tx_out_sop,
  output logic              tx_out_eop,
  output logic              tx_out_valid,
  input  logic              tx_out_ready,
  output logic [DW-1:0]     tx_out_data,
  output logic [CIW-1:0]    tx_out_ch,
  output logic              tx_eop_en,
  output logic              tx_drop,
  output logic              busy
);

  localparam int EW = 2 + DW + CIW;

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CIW-1:0]  grant, grant_nxt;
  logic [CH-1:0]   sop_req;
  logic            win_found, drop_found;
  logic [CIW-1:0]  win_idx, drop_idx, sel;
  logic            push, pop, drop, full;
  logic [1:0]      count;
  logic            wr_ptr, rd_ptr;
  logic [EW-1:0]   fifo_mem [2];
  logic [EW-1:0]   push_entry, head;
  logic [DW-1:0]   ch_data [CH];
  int              start;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign ch_data[g] = tx_in_data[g*DW +: DW];
  end

`ifdef TX_ARB_RR_EN
  logic [CIW-1:0] rr_ptr;
  assign start = int'(rr_ptr);
`else
  assign start = 0;
`endif

  // Arbiter: pick the sop requester closest to 'start' going upward with
  // wrap-around. Separately, pick the lowest-index valid channel; it is used
  // when there is no sop request at all.
  always_comb begin
    sop_req    = tx_in_valid & tx_in_sop;
    win_found  = 1'b0;
    win_idx    = '0;
    drop_found = 1'b0;
    drop_idx   = '0;
    // Wrapped-around candidates have lower priority and are written first.
    for (int j = CH - 1; j >= 0; j--) begin
      if (sop_req[j] && (j < start)) begin
        win_found = 1'b1;
        win_idx   = CIW'(j);
      end
    end
    // A candidate at or above 'start' overrides them. The lowest such index wins.
    for (int j = CH - 1; j >= 0; j--) begin
      if (sop_req[j] && (j >= start)) begin
        win_found = 1'b1;
        win_idx   = CIW'(j);
      end
    end
    for (int j = CH - 1; j >= 0; j--) begin
      if (tx_in_valid[j]) begin
        drop_found = 1'b1;
        drop_idx   = CIW'(j);
      end
    end
  end

  // FSM next state, per-channel ready, and FIFO push / orphan drop decisions.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    tx_in_ready = '0;
    push        = 1'b0;
    drop        = 1'b0;
    sel         = grant;
    full        = (count == 2'd2);
    case (state)
      S_IDLE: begin
        if (win_found) begin
          sel                  = win_idx;
          tx_in_ready[win_idx] = !full;
          push                 = !full;
          if (!full) begin
            grant_nxt = win_idx;
            if (!tx_in_eop[win_idx]) state_nxt = S_LOCK;
          end
        end else if (drop_found) begin
          // A beat without sop arriving outside a packet is swallowed. It
          // needs no FIFO space, so it is accepted unconditionally.
          tx_in_ready[drop_idx] = 1'b1;
          drop                  = 1'b1;
        end
      end
      S_LOCK: begin
        tx_in_ready[grant] = !full;
        push               = tx_in_valid[grant] && !full;
        if (push && tx_in_eop[grant]) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Keep every handshake quiet while reset is held.
    if (!rst_n) begin
      tx_in_ready = '0;
      push        = 1'b0;
      drop        = 1'b0;
    end
  end

  assign push_entry   = {tx_in_sop[sel], tx_in_eop[sel], ch_data[sel], sel};
  assign head         = fifo_mem[rd_ptr];
  assign tx_out_valid = (count != 2'd0);
  assign pop          = tx_out_valid & tx_out_ready;
  // The FIFO storage is not reset. Masking the head with valid forces the
  // output fields to zero whenever the FIFO is empty, including during reset.
  assign {tx_out_sop, tx_out_eop, tx_out_data, tx_out_ch} = tx_out_valid ? head : '0;
  assign tx_eop_en    = pop & tx_out_eop;
  assign tx_drop      = drop;
  assign busy         = (state == S_LOCK) | tx_out_valid;

  // Control registers: FSM state, granted channel, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      grant  <= '0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: holds beat payload only, so it is written without a reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_entry;
  end

`ifdef TX_ARB_RR_EN
  // Round-robin pointer: the next search starts just past the last sop winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push && (state == S_IDLE)) begin
      rr_ptr <= (int'(win_idx) == CH - 1) ? '0 : win_idx + CIW'(1);
    end
  end
`endif

endmodule
